perf_stat_monitor: RTL and testbench

//  Synthesizable pipeline performance monitor beside the 5-stage core (main).

---
 rtl/perf_stat_monitor.sv | 198 +++++++++++++++++++
 tb/tb_perf_stat_monitor.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/perf_stat_monitor.sv
// Performance monitor beside the 5-stage core: per-class retire counts, stall cycles and HALT drain.
// Define PERF_SATURATE_EN to clamp counters and derived sums at all-ones instead of wrapping.
module perf_stat_monitor #(
   parameter int          NUM_CLASSES   = 4,
   parameter int          CNT_W         = 32,
   parameter logic [5:0]  HALT_OPCODE   = 6'b010001,
   parameter int          PIPE_OVERHEAD = 6,
   parameter int          DRAIN_CYCLES  = 6,
   localparam int         CLS_W         = $clog2(NUM_CLASSES),
   localparam int         RD_AW         = $clog2(NUM_CLASSES + 6)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             retire_valid,
   input  logic [31:0]      retire_inst,
   input  logic [CLS_W-1:0] retire_class,
   input  logic             stall_fwd,
   input  logic             stall_nofwd,
   input  logic             clear,
   input  logic             rd_en,
   input  logic [RD_AW-1:0] rd_addr,
   output logic [CNT_W-1:0] rd_data,
   output logic             rd_valid,
   output logic             halted,
   output logic             ovf
);

   typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_e;

   localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);
   localparam int SUM_W = CNT_W + 2;

   typedef logic [CNT_W-1:0] cnt_t;
   typedef logic [SUM_W-1:0] sum_t;

   localparam cnt_t CNT_MAX = '1;

   // Returns {overflow_event, next_value} for a single increment.
   function automatic logic [CNT_W:0] bump(input cnt_t v);
`ifdef PERF_SATURATE_EN
      if (v == CNT_MAX) return {1'b1, v};
      return {1'b0, v + cnt_t'(1)};
`else
      return {v == CNT_MAX, v + cnt_t'(1)};
`endif
   endfunction

   function automatic cnt_t derived(input cnt_t a, input cnt_t b);
      sum_t s;
      s = sum_t'(a) + sum_t'(b) + sum_t'(PIPE_OVERHEAD);
`ifdef PERF_SATURATE_EN
      return (s > sum_t'(CNT_MAX)) ? CNT_MAX : cnt_t'(s);
`else
      return cnt_t'(s);
`endif
   endfunction

   state_e             state_q, state_d;
   logic [DRN_W-1:0]   drain_q, drain_d;
   cnt_t               cls_cnt_q [NUM_CLASSES];
   cnt_t               cls_cnt_d [NUM_CLASSES];
   cnt_t               inst_total_q, inst_total_d;
   cnt_t               stall_wo_q, stall_wo_d;
   cnt_t               stall_w_q, stall_w_d;
   cnt_t               cycle_cnt_q, cycle_cnt_d;
   logic               ovf_q, ovf_d;
   cnt_t               rd_data_q, rd_data_d;
   logic               rd_valid_q, rd_valid_d;
   cnt_t               rd_mux;
   logic [CNT_W:0]     r;
   logic               inst_unused;

   assign inst_unused = ^retire_inst[25:0];

   // Read mux looks only at _q values, so a read returns the state before this cycle's update.
   always_comb begin
      int idx;
      idx    = int'(rd_addr);
      rd_mux = '0;
      for (int i = 0; i < NUM_CLASSES; i++) begin
         if (idx == i) rd_mux = cls_cnt_q[i];
      end
      if      (idx == NUM_CLASSES)     rd_mux = inst_total_q;
      else if (idx == NUM_CLASSES + 1) rd_mux = stall_wo_q;
      else if (idx == NUM_CLASSES + 2) rd_mux = stall_w_q;
      else if (idx == NUM_CLASSES + 3) rd_mux = derived(inst_total_q, stall_wo_q);
      else if (idx == NUM_CLASSES + 4) rd_mux = derived(inst_total_q, stall_w_q);
      else if (idx == NUM_CLASSES + 5) rd_mux = cycle_cnt_q;
   end

   always_comb begin
      // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
      state_d      = state_q;
      drain_d      = drain_q;
      cls_cnt_d    = cls_cnt_q;
      inst_total_d = inst_total_q;
      stall_wo_d   = stall_wo_q;
      stall_w_d    = stall_w_q;
      cycle_cnt_d  = cycle_cnt_q;
      ovf_d        = ovf_q;
      r            = '0;

      unique case (state_q)
         ST_RUN: begin
            r           = bump(cycle_cnt_q);
            cycle_cnt_d = r[CNT_W-1:0];
            ovf_d       = ovf_d | r[CNT_W];
            if (retire_valid) begin
               r            = bump(inst_total_q);
               inst_total_d = r[CNT_W-1:0];
               ovf_d        = ovf_d | r[CNT_W];
               for (int i = 0; i < NUM_CLASSES; i++) begin
                  if (int'(retire_class) == i) begin
                     r            = bump(cls_cnt_q[i]);
                     cls_cnt_d[i] = r[CNT_W-1:0];
                     ovf_d        = ovf_d | r[CNT_W];
                  end
               end
               if (retire_inst[31:26] == HALT_OPCODE) begin
                  state_d = ST_DRAIN;
                  drain_d = '0;
               end
            end
            if (stall_nofwd) begin
               r          = bump(stall_wo_q);
               stall_wo_d = r[CNT_W-1:0];
               ovf_d      = ovf_d | r[CNT_W];
            end
            if (stall_fwd) begin
               r         = bump(stall_w_q);
               stall_w_d = r[CNT_W-1:0];
               ovf_d     = ovf_d | r[CNT_W];
            end
         end
         ST_DRAIN: begin
            r           = bump(cycle_cnt_q);
            cycle_cnt_d = r[CNT_W-1:0];
            ovf_d       = ovf_d | r[CNT_W];
            if (drain_q == DRN_W'(DRAIN_CYCLES - 1)) begin
               state_d = ST_HALTED;
               drain_d = '0;
            end else begin
               drain_d = drain_q + DRN_W'(1);
            end
         end
         ST_HALTED: ;
         default: state_d = ST_RUN;
      endcase

      if (clear) begin
         state_d      = ST_RUN;
         drain_d      = '0;
         cls_cnt_d    = '{default: '0};
         inst_total_d = '0;
         stall_wo_d   = '0;
         stall_w_d    = '0;
         cycle_cnt_d  = '0;
         ovf_d        = 1'b0;
      end

      rd_valid_d = rd_en;
      rd_data_d  = rd_en ? rd_mux : rd_data_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_RUN;
         drain_q      <= '0;
         // NOTE: the counter array is register-based and must read 0 after reset, so it is reset too.
         cls_cnt_q    <= '{default: '0};
         inst_total_q <= '0;
         stall_wo_q   <= '0;
         stall_w_q    <= '0;
         cycle_cnt_q  <= '0;
         ovf_q        <= 1'b0;
         rd_data_q    <= '0;
         rd_valid_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge values of the others.
         state_q      <= state_d;
         drain_q      <= drain_d;
         cls_cnt_q    <= cls_cnt_d;
         inst_total_q <= inst_total_d;
         stall_wo_q   <= stall_wo_d;
         stall_w_q    <= stall_w_d;
         cycle_cnt_q  <= cycle_cnt_d;
         ovf_q        <= ovf_d;
         rd_data_q    <= rd_data_d;
         rd_valid_q   <= rd_valid_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign halted   = (state_q == ST_HALTED);
   assign ovf      = ovf_q;

endmodule

// File: tb/tb_perf_stat_monitor.sv
// Scoreboard bench for perf_stat_monitor: a 32-bit instance plus a 4-bit instance for wrap/saturate.
module tb_perf_stat_monitor;

   localparam logic [31:0] HALT_INST = 32'h4400_0000;
   localparam logic [31:0] PLAIN     = 32'h8C00_0000;
`ifdef PERF_SATURATE_EN
   localparam logic [31:0] SMALL_EXP = 32'd15;
`else
   localparam logic [31:0] SMALL_EXP = 32'd1;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        retire_valid;
   logic [31:0] retire_inst;
   logic [1:0]  retire_class;
   logic        stall_fwd, stall_nofwd, clear, rd_en, rd_en_s;
   logic [3:0]  rd_addr;
   logic [31:0] rd_data;
   logic        rd_valid, halted, ovf;
   logic [3:0]  rd_data_s;
   logic        rd_valid_s, halted_s, ovf_s;

   typedef struct {
      logic [3:0]  addr;
      logic [31:0] data;
   } exp_t;

   exp_t exp_q[$];
   exp_t exp_s_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   perf_stat_monitor dut (
      .clk(clk), .reset(reset), .retire_valid(retire_valid), .retire_inst(retire_inst),
      .retire_class(retire_class), .stall_fwd(stall_fwd), .stall_nofwd(stall_nofwd),
      .clear(clear), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .rd_valid(rd_valid), .halted(halted), .ovf(ovf)
   );

   perf_stat_monitor #(.CNT_W(4)) dut_small (
      .clk(clk), .reset(reset), .retire_valid(retire_valid), .retire_inst(retire_inst),
      .retire_class(retire_class), .stall_fwd(stall_fwd), .stall_nofwd(stall_nofwd),
      .clear(clear), .rd_en(rd_en_s), .rd_addr(rd_addr), .rd_data(rd_data_s),
      .rd_valid(rd_valid_s), .halted(halted_s), .ovf(ovf_s)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input logic rv, input logic [31:0] inst, input logic [1:0] cls,
                        input logic sf, input logic snf, input logic clr,
                        input logic re, input logic re_s, input logic [3:0] addr);
      retire_valid = rv;
      retire_inst  = inst;
      retire_class = cls;
      stall_fwd    = sf;
      stall_nofwd  = snf;
      clear        = clr;
      rd_en        = re;
      rd_en_s      = re_s;
      rd_addr      = addr;
      @(negedge clk);
   endtask

   task automatic step(input logic rv, input logic [31:0] inst, input logic [1:0] cls,
                       input logic sf, input logic snf, input logic clr);
      drive(rv, inst, cls, sf, snf, clr, 1'b0, 1'b0, 4'd0);
   endtask

   task automatic idle();
      step(1'b0, PLAIN, 2'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic rd(input logic [3:0] a, input logic [31:0] e);
      exp_q.push_back('{addr: a, data: e});
      drive(1'b0, PLAIN, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, a);
   endtask

   task automatic rd_both(input logic [3:0] a, input logic [31:0] e, input logic [31:0] e_s);
      exp_q.push_back('{addr: a, data: e});
      exp_s_q.push_back('{addr: a, data: e_s});
      drive(1'b0, PLAIN, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, a);
   endtask

   // Monitor: compares read data against the scoreboard whenever either DUT presents rd_valid.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) check("main unexpected rd_valid", {31'd0, rd_valid}, 32'd0);
            else begin
               e = exp_q.pop_front();
               check($sformatf("main read addr %0d", e.addr), rd_data, e.data);
            end
         end
         if (rd_valid_s === 1'b1) begin
            if (exp_s_q.size() == 0) check("small unexpected rd_valid", {31'd0, rd_valid_s}, 32'd0);
            else begin
               e = exp_s_q.pop_front();
               check($sformatf("small read addr %0d", e.addr), {28'd0, rd_data_s}, e.data);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b0;
      retire_valid = 1'b0; retire_inst = PLAIN; retire_class = 2'd0;
      stall_fwd = 1'b0; stall_nofwd = 1'b0; clear = 1'b0;
      rd_en = 1'b0; rd_en_s = 1'b0; rd_addr = 4'd0;
      repeat (3) @(negedge clk);
      check("reset rd_valid", {31'd0, rd_valid}, 32'd0);
      check("reset rd_data", rd_data, 32'd0);
      check("reset halted", {31'd0, halted}, 32'd0);
      check("reset ovf", {31'd0, ovf}, 32'd0);
      reset = 1'b1;

      // Per-class retire counts
      repeat (3) step(1'b1, PLAIN, 2'd0, 1'b0, 1'b0, 1'b0);
      repeat (2) step(1'b1, PLAIN, 2'd1, 1'b0, 1'b0, 1'b0);
      repeat (4) step(1'b1, PLAIN, 2'd2, 1'b0, 1'b0, 1'b0);
      step(1'b1, PLAIN, 2'd3, 1'b0, 1'b0, 1'b0);
      rd(4'd0, 32'd3); rd(4'd1, 32'd2); rd(4'd2, 32'd4); rd(4'd3, 32'd1);
      rd(4'd4, 32'd10); rd(4'd7, 32'd16); rd(4'd10, 32'd0);

      // Stall counters and derived clock totals
      step(1'b0, PLAIN, 2'd0, 1'b0, 1'b0, 1'b1);
      rd(4'd0, 32'd0);
      repeat (10) step(1'b1, PLAIN, 2'd1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, PLAIN, 2'd0, (i < 2), 1'b1, 1'b0);
      rd(4'd1, 32'd10); rd(4'd5, 32'd5); rd(4'd6, 32'd2); rd(4'd8, 32'd18); rd(4'd7, 32'd21);
      idle();
      check("rd_data hold", rd_data, 32'd21);

      // HALT at cycle 20, drain, freeze
      step(1'b0, PLAIN, 2'd0, 1'b0, 1'b0, 1'b1);
      repeat (5) step(1'b1, PLAIN, 2'd0, 1'b0, 1'b0, 1'b0);
      repeat (14) idle();
      step(1'b1, HALT_INST, 2'd3, 1'b0, 1'b0, 1'b0);
      repeat (5) step(1'b1, PLAIN, 2'd0, 1'b1, 1'b1, 1'b0);
      check("halted during drain", {31'd0, halted}, 32'd0);
      step(1'b1, PLAIN, 2'd0, 1'b1, 1'b1, 1'b0);
      check("halted after drain", {31'd0, halted}, 32'd1);
      repeat (2) step(1'b1, PLAIN, 2'd0, 1'b1, 1'b1, 1'b0);
      rd(4'd0, 32'd5); rd(4'd3, 32'd1); rd(4'd4, 32'd6); rd(4'd5, 32'd0);
      rd(4'd9, 32'd26); rd(4'd7, 32'd12);
      check("halted holds", {31'd0, halted}, 32'd1);

      // clear beats a simultaneous HALT retire
      step(1'b1, HALT_INST, 2'd3, 1'b0, 1'b0, 1'b1);
      check("halted after clear", {31'd0, halted}, 32'd0);
      rd(4'd9, 32'd0); rd(4'd3, 32'd0); rd(4'd4, 32'd0);
      repeat (6) idle();
      check("halted stays low", {31'd0, halted}, 32'd0);
      check("ovf after clear", {31'd0, ovf}, 32'd0);

      // 4-bit counters: 17 arith retires wrap (or clamp)
      step(1'b0, PLAIN, 2'd0, 1'b0, 1'b0, 1'b1);
      check("small ovf cleared", {31'd0, ovf_s}, 32'd0);
      repeat (17) step(1'b1, PLAIN, 2'd0, 1'b0, 1'b0, 1'b0);
      rd_both(4'd0, 32'd17, SMALL_EXP);
      rd_both(4'd4, 32'd17, SMALL_EXP);
      check("small ovf set", {31'd0, ovf_s}, 32'd1);
      check("main ovf clear", {31'd0, ovf}, 32'd0);

      // Reset mid-DRAIN with a read in flight
      step(1'b1, HALT_INST, 2'd3, 1'b0, 1'b0, 1'b0);
      repeat (2) idle();
      rd_en = 1'b1; rd_addr = 4'd4;
      #2 reset = 1'b0;
      @(posedge clk); #1;
      check("mid-drain reset rd_valid", {31'd0, rd_valid}, 32'd0);
      check("mid-drain reset rd_data", rd_data, 32'd0);
      check("mid-drain reset halted", {31'd0, halted}, 32'd0);
      check("mid-drain reset ovf", {31'd0, ovf}, 32'd0);
      @(negedge clk);
      rd_en = 1'b0;
      reset = 1'b1;
      rd(4'd9, 32'd0); rd(4'd10, 32'd0); rd(4'd0, 32'd0); rd(4'd3, 32'd0); rd(4'd4, 32'd0);
      repeat (4) idle();
      check("halted after reset drain", {31'd0, halted}, 32'd0);
      check("main pending reads", exp_q.size(), 32'd0);
      check("small pending reads", exp_s_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
